rng_sched: RTL and testbench

Round-robin scheduler sharing one 7-bit LFSR random source among `NREQ` requesters in the public-key decryption datapath (key/nonce generation, blinding). It owns the LFSR, advances it only while drawing, and performs per-requester rejection sampling against an upper bound. Each grant returns exactly one accepted 7-bit value.

---
 rtl/rng_sched_pkg.sv | 29 ++
 rtl/lfsr7.sv | 43 ++++
 rtl/rng_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_rng_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rng_sched_pkg.sv
// -----------------------------------------------------------------------------
// rng_sched_pkg
// Shared definitions for the round-robin random-number scheduler:
//   - state_e       : scheduler FSM states (IDLE / DRAW / GRANT)
//   - LFSR_W        : random source width (7 bits)
//   - LFSR_TAPS     : feedback tap mask, bits 6..3 XORed into bit 0
//   - DEFAULT_SEED  : nonzero reset value of the LFSR
//   - lfsr_next()   : one Fibonacci step of the 7-bit maximal-length LFSR
// No ports (package).
// -----------------------------------------------------------------------------
package rng_sched_pkg;

   localparam int              LFSR_W       = 7;
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 7'b1111000;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAW  = 2'd1,
      ST_GRANT = 2'd2
   } state_e;

   // Shift left, feed the XOR of the tapped bits into bit 0. With taps 6..3
   // the sequence has period 127 and never reaches the all-zero state.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage : rng_sched_pkg

// File: rtl/lfsr7.sv
// -----------------------------------------------------------------------------
// lfsr7
// 7-bit maximal-length LFSR that advances by one step per cycle while `en`
// is high and holds otherwise.
// Parameters:
//   SEED  nonzero value loaded on reset
// Ports:
//   clk   in   clock, all logic on posedge
//   rst   in   synchronous active-high reset (loads SEED)
//   en    in   advance the LFSR this cycle
//   q     out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr7
   import rng_sched_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] q_q;
   logic [LFSR_W-1:0] q_d;

   always_comb begin
      q_d = en ? lfsr_next(q_q) : q_q;
   end

   // NOTE: flops use non-blocking (<=) so every register samples the values
   // from before the edge; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : lfsr7

// File: rtl/rng_sched.sv
// -----------------------------------------------------------------------------
// rng_sched
// Round-robin scheduler sharing one 7-bit LFSR among NREQ requesters. A
// granted requester receives exactly one accepted random value; with
// rejection sampling enabled, draws at or above the requester's bound are
// discarded and retried, and after MAX_TRIES rejections the grant is forced
// with err=1 and rnd=0.
//
// Build option (macro RNG_SCHED_REJECT_EN):
//   defined   : rejection sampling against lim, try counter and err built
//   undefined : every draw accepted, lim ignored, err tied low
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   SEED       nonzero LFSR reset value
//   MAX_TRIES  rejected draws before a forced grant with err
// Ports:
//   clk   in   clock, all logic on posedge
//   rst   in   synchronous active-high reset
//   req   in   [NREQ]    level request per requester, held until its gnt
//   lim   in   [7*NREQ]  exclusive upper bound per requester, 0 = unbounded
//   gnt   out  [NREQ]    one-hot, one-cycle grant (registered)
//   rnd   out  [7]       value delivered with gnt, held until next grant
//   err   out            set with gnt when MAX_TRIES was exhausted
//   busy  out            high while in DRAW or GRANT
// -----------------------------------------------------------------------------
module rng_sched
   import rng_sched_pkg::*;
#(
   parameter int                NREQ      = 4,
   parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED,
   parameter int                MAX_TRIES = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [LFSR_W*NREQ-1:0] lim,
   output logic [NREQ-1:0]        gnt,
   output logic [LFSR_W-1:0]      rnd,
   output logic                   err,
   output logic                   busy
);

   localparam int              IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e            state_q, state_d;
   // win_q is both the index being served and, after GRANT, the last winner
   // that the next arbitration rotates from. Every latched winner reaches
   // GRANT unless reset intervenes, and reset reloads it anyway.
   logic [IDX_W-1:0]  win_q,   win_d;
   logic [NREQ-1:0]   gnt_q,   gnt_d;
   logic [LFSR_W-1:0] rnd_q,   rnd_d;
   logic              busy_q,  busy_d;

   logic              lfsr_en;
   logic [LFSR_W-1:0] lfsr_q;

   lfsr7 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (lfsr_en),
      .q   (lfsr_q)
   );

`ifdef RNG_SCHED_REJECT_EN
   localparam int CNT_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   logic [LFSR_W-1:0] lim_q, lim_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              draw_ok;

   // lim_q == 0 encodes a bound of 128, i.e. every 7-bit value is accepted.
   assign draw_ok = (lim_q == '0) || (lfsr_q < lim_q);
`else
   // Bounds are not used in this build; fold them into a sink net.
   logic lim_unused;
   assign lim_unused = ^lim;
`endif

   // ---------------------------------------------------------------------
   // Round-robin pick: the lowest requesting index above the last winner,
   // otherwise wrap to the lowest requesting index overall. The loops run
   // downward so the lowest qualifying index is the one left standing.
   // ---------------------------------------------------------------------
   logic              hi_vld, lo_vld;
   logic [IDX_W-1:0]  hi_idx, lo_idx;
   logic              pick_vld;
   logic [IDX_W-1:0]  pick_idx;
   logic [LFSR_W-1:0] pick_lim;

   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_vld = 1'b1;
            lo_idx = IDX_W'(i);
            if (IDX_W'(i) > win_q) begin
               hi_vld = 1'b1;
               hi_idx = IDX_W'(i);
            end
         end
      end
      pick_vld = lo_vld;
      pick_idx = hi_vld ? hi_idx : lo_idx;

      pick_lim = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDX_W'(i) == pick_idx) begin
            pick_lim = lim[LFSR_W*i +: LFSR_W];
         end
      end
   end

   logic [NREQ-1:0] win_onehot;
   assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

   // ---------------------------------------------------------------------
   // FSM next-state and registered-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case statement so no
      // path leaves it unassigned; a missing default would infer a latch.
      state_d = state_q;
      win_d   = win_q;
      gnt_d   = '0;
      rnd_d   = rnd_q;
      lfsr_en = 1'b0;
`ifdef RNG_SCHED_REJECT_EN
      lim_d   = lim_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_DRAW;
               win_d   = pick_idx;
`ifdef RNG_SCHED_REJECT_EN
               lim_d   = pick_lim;
               cnt_d   = '0;
`endif
            end
         end

         ST_DRAW: begin
            // The current value is consumed whether accepted or not.
            lfsr_en = 1'b1;
`ifdef RNG_SCHED_REJECT_EN
            if (draw_ok) begin
               rnd_d   = lfsr_q;
               err_d   = 1'b0;
               gnt_d   = win_onehot;
               state_d = ST_GRANT;
            end else if (cnt_q == CNT_W'(MAX_TRIES - 1)) begin
               // This rejection is the MAX_TRIES-th: force the grant.
               rnd_d   = '0;
               err_d   = 1'b1;
               gnt_d   = win_onehot;
               state_d = ST_GRANT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`else
            rnd_d   = lfsr_q;
            gnt_d   = win_onehot;
            state_d = ST_GRANT;
`endif
         end

         ST_GRANT: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         win_q   <= LAST_IDX;
         gnt_q   <= '0;
         rnd_q   <= '0;
         busy_q  <= 1'b0;
`ifdef RNG_SCHED_REJECT_EN
         lim_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         gnt_q   <= gnt_d;
         rnd_q   <= rnd_d;
         busy_q  <= busy_d;
`ifdef RNG_SCHED_REJECT_EN
         lim_q   <= lim_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign rnd  = rnd_q;
   assign busy = busy_q;
`ifdef RNG_SCHED_REJECT_EN
   assign err  = err_q;
`else
   assign err  = 1'b0;
`endif

endmodule : rng_sched

// File: tb/tb_rng_sched.sv
// -----------------------------------------------------------------------------
// tb_rng_sched
// Self-checking bench for rng_sched. A transaction-level reference model
// derives, for every request pattern, the expected winner, the number of
// draws, the delivered value, err, and the request-to-grant latency, using a
// precomputed table of the LFSR sequence.
// -----------------------------------------------------------------------------
module tb_rng_sched;

   localparam int         NREQ = 4;
   localparam int         MAXT = 16;
   localparam logic [6:0] SEED = 7'h23;
`ifdef RNG_SCHED_REJECT_EN
   localparam bit REJ = 1'b1;
`else
   localparam bit REJ = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [7*NREQ-1:0] lim = '0;
   logic [NREQ-1:0] gnt;
   logic [6:0]      rnd;
   logic            err;
   logic            busy;

   always #5 clk = ~clk;

   rng_sched #(
      .NREQ      (NREQ),
      .SEED      (SEED),
      .MAX_TRIES (MAXT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .lim  (lim),
      .gnt  (gnt),
      .rnd  (rnd),
      .err  (err),
      .busy (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   int seq [127];   // LFSR values in order of appearance, seq[0] = SEED
   int pos;         // index of the next value the DUT will draw
   int last_w;      // last granted requester
   int hold_rnd;    // value rnd must hold between grants
   int hold_err;

   function automatic int lfsr_step(input int v);
      int fb;
      fb = ((v >> 3) ^ (v >> 4) ^ (v >> 5) ^ (v >> 6)) & 1;
      return ((v << 1) & 127) | fb;
   endfunction

   task automatic model_reset();
      pos      = 0;
      last_w   = NREQ - 1;
      hold_rnd = 0;
      hold_err = 0;
   endtask

   function automatic logic [7*NREQ-1:0] rand_lim();
      logic [7*NREQ-1:0] l;
      int sel;
      l = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0)      l[7*i +: 7] = 7'd0;
         else if (sel == 1) l[7*i +: 7] = 7'($urandom_range(1, 8));
         else               l[7*i +: 7] = 7'($urandom_range(1, 127));
      end
      return l;
   endfunction

   // Entered and left at #1 after a posedge with the DUT in IDLE.
   task automatic txn(input logic [NREQ-1:0] r, input logic [7*NREQ-1:0] l, input bit scramble);
      int w, limw, bound, draws, rejects, v, exp_rnd, exp_err, n, c;
      bit done, seen;
      req = r;
      lim = l;
      @(negedge clk);
      check("idle_gnt",  gnt,  0);
      check("idle_busy", busy, 0);
      check("hold_rnd",  rnd,  hold_rnd);
      check("hold_err",  err,  hold_err);
      if (r == '0) begin
         @(posedge clk); #1;
         return;
      end

      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
         c = (last_w + k) % NREQ;
         if (w < 0 && r[c]) w = c;
      end
      limw  = int'((l >> (7 * w)) & 127);
      bound = (REJ && limw != 0) ? limw : 128;

      draws = 0; rejects = 0; done = 1'b0; exp_rnd = 0; exp_err = 0;
      while (!done) begin
         v   = seq[pos];
         pos = (pos + 1) % 127;
         draws++;
         if (v < bound) begin
            exp_rnd = v; exp_err = 0; done = 1'b1;
         end else begin
            rejects++;
            if (rejects == MAXT) begin
               exp_rnd = 0; exp_err = 1; done = 1'b1;
            end
         end
      end

      seen = 1'b0; n = 0;
      while (!seen && n < MAXT + 4) begin
         @(posedge clk); #1;
         n++;
         if (scramble) begin
            // Late bound changes and a dropped request must not matter.
            lim = rand_lim();
            if (n == 1) req[w] = 1'b0;
         end
         @(negedge clk);
         if (gnt != '0) seen = 1'b1;
         else           check("draw_busy", busy, 1);
      end
      check("gnt_seen", seen, 1);
      if (seen) begin
         check("latency",    n,    draws + 1);
         check("gnt",        gnt,  1 << w);
         check("rnd",        rnd,  exp_rnd);
         check("err",        err,  exp_err);
         check("grant_busy", busy, 1);
      end
      last_w   = w;
      hold_rnd = exp_rnd;
      hold_err = exp_err;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("rst_gnt",  gnt,  0);
      check("rst_rnd",  rnd,  0);
      check("rst_err",  err,  0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
   endtask

`ifndef RNG_SCHED_REJECT_EN
   bit seen_v [128];
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      seq[0] = int'(SEED);
      for (int i = 1; i < 127; i++) seq[i] = lfsr_step(seq[i-1]);
      model_reset();

      do_reset();

      // First grant after reset delivers the seed.
      txn(4'b0001, '0, 1'b0);
      // Requester 1 with bound 0x20.
      txn(4'b0010, 28'(28'h20 << 7), 1'b0);

      // Reset while drawing: no grant, draw discarded.
      req = 4'b0100;
      lim = '0;
      @(posedge clk); #1;
      @(negedge clk);
      check("middraw_busy", busy, 1);
      rst = 1'b1;
      req = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check("midrst_gnt",  gnt,  0);
      check("midrst_busy", busy, 0);
      check("midrst_rnd",  rnd,  0);
      check("midrst_err",  err,  0);
      @(posedge clk); #1;

      // All requesting: grants rotate 0,1,2,3,0; first one returns the seed.
      repeat (5) txn(4'b1111, '0, 1'b0);

      // Bound 1 can never be met by a nonzero LFSR value.
      txn(4'b0100, 28'(28'd1 << 14), 1'b0);

      // Randomised traffic.
      repeat (60) txn(4'($urandom), rand_lim(), 1'($urandom_range(0, 1)));

`ifndef RNG_SCHED_REJECT_EN
      // A full LFSR period of grants: pairwise distinct and nonzero.
      do_reset();
      for (int i = 0; i < 128; i++) seen_v[i] = 1'b0;
      repeat (127) begin
         txn(4'($urandom_range(1, 15)), rand_lim(), 1'b0);
         check("nonzero",  rnd != 7'd0, 1);
         check("distinct", seen_v[rnd], 0);
         seen_v[rnd] = 1'b1;
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_rng_sched
